// File: rtl/execute_stage_fwd_if.sv
// Execute-stage bus: E-stage instruction in, branch resolution out, E/M register out.
interface execute_stage_fwd_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  valid_e;
  logic                  ready_e;
  logic                  flush_e;
  logic                  stall_m;
  logic [XLEN-1:0]       rd1_e;
  logic [XLEN-1:0]       rd2_e;
  logic [XLEN-1:0]       imm_ext_e;
  logic [XLEN-1:0]       pc_e;
  logic [XLEN-1:0]       pc_plus4_e;
  logic [2:0]            alu_control_e;
  logic                  alu_src_e;
  logic                  reg_write_e;
  logic                  mem_write_e;
  logic                  branch_e;
  logic                  mul_e;
  logic [1:0]            result_src_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [1:0]            forward_a_e;
  logic [1:0]            forward_b_e;
  logic [XLEN-1:0]       result_w;
  logic                  pc_src_e;
  logic [XLEN-1:0]       pc_target_e;
  logic                  valid_m;
  logic                  reg_write_m;
  logic                  mem_write_m;
  logic [1:0]            result_src_m;
  logic [REG_ADDR_W-1:0] rd_m;
  logic [XLEN-1:0]       alu_result_m;
  logic [XLEN-1:0]       write_data_m;
  logic [XLEN-1:0]       pc_plus4_m;

  modport master (
    output valid_e, flush_e, stall_m, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
           alu_control_e, alu_src_e, reg_write_e, mem_write_e, branch_e, mul_e,
           result_src_e, rd_e, forward_a_e, forward_b_e, result_w,
    input  ready_e, pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m,
           result_src_m, rd_m, alu_result_m, write_data_m, pc_plus4_m
  );

  modport slave (
    input  valid_e, flush_e, stall_m, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
           alu_control_e, alu_src_e, reg_write_e, mem_write_e, branch_e, mul_e,
           result_src_e, rd_e, forward_a_e, forward_b_e, result_w,
    output ready_e, pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m,
           result_src_m, rd_m, alu_result_m, write_data_m, pc_plus4_m
  );
endinterface

// File: rtl/execute_stage_fwd.sv
// Execute stage: operand forwarding, ALU, branch resolution and the E/M pipeline register.
// Define EXEC_MUL_EN to add an iterative shift-add multiplier (one bit per cycle).
module execute_stage_fwd #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic                clk,
  input logic                rst,
  execute_stage_fwd_if.slave bus
);

  logic [XLEN-1:0]       srcA, fwdB, srcB, aluResult;
  logic                  ready, accept, mulIdle, mulStart;

  logic                  validM, regWriteM, memWriteM;
  logic [1:0]            resultSrcM;
  logic [REG_ADDR_W-1:0] rdM;
  logic [XLEN-1:0]       aluResultM, writeDataM, pcPlus4M;

  always_comb begin
    case (bus.forward_a_e)
      2'b01:   srcA = bus.result_w;
      2'b10:   srcA = aluResultM;
      default: srcA = bus.rd1_e;
    endcase
    case (bus.forward_b_e)
      2'b01:   fwdB = bus.result_w;
      2'b10:   fwdB = aluResultM;
      default: fwdB = bus.rd2_e;
    endcase
    srcB = bus.alu_src_e ? bus.imm_ext_e : fwdB;
  end

  always_comb begin
    case (bus.alu_control_e)
      3'b000:  aluResult = srcA + srcB;
      3'b001:  aluResult = srcA - srcB;
      3'b010:  aluResult = srcA & srcB;
      3'b011:  aluResult = srcA | srcB;
      3'b101:  aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: aluResult = '0;
    endcase
  end

  assign ready           = !bus.stall_m && mulIdle;
  assign accept          = bus.valid_e && ready && !bus.flush_e;
  assign bus.ready_e     = ready;
  assign bus.pc_src_e    = accept && bus.branch_e && (aluResult == '0);
  assign bus.pc_target_e = bus.pc_e + bus.imm_ext_e;

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} mulStateT;
  localparam int unsigned CntW = $clog2(XLEN);

  mulStateT              mulState;
  logic [CntW-1:0]       mulCnt;
  logic [XLEN-1:0]       mcand, mplier, mulAcc, mulWriteData, mulPcPlus4;
  logic                  mulRegWrite, mulMemWrite, mulFire;
  logic [1:0]            mulResultSrc;
  logic [REG_ADDR_W-1:0] mulRd;

  assign mulIdle  = (mulState == StIdle);
  assign mulStart = accept && bus.mul_e;
  // A finished product retires only into a free E/M slot; a flush discards it instead.
  assign mulFire  = (mulState == StDone) && !bus.stall_m && !bus.flush_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      mulState <= StIdle;
      mulCnt   <= '0;
    end else begin
      unique case (mulState)
        StIdle: begin
          if (mulStart) begin
            mcand        <= srcA;
            mplier       <= srcB;
            mulAcc       <= '0;
            mulCnt       <= '0;
            mulRegWrite  <= bus.reg_write_e;
            mulMemWrite  <= bus.mem_write_e;
            mulResultSrc <= bus.result_src_e;
            mulRd        <= bus.rd_e;
            mulWriteData <= fwdB;
            mulPcPlus4   <= bus.pc_plus4_e;
            mulState     <= StBusy;
          end
        end
        StBusy: begin
          if (bus.flush_e) begin
            mulState <= StIdle;
          end else begin
            if (mplier[0]) mulAcc <= mulAcc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            mulCnt <= mulCnt + 1'b1;
            if (mulCnt == CntW'(XLEN - 1)) mulState <= StDone;
          end
        end
        StDone: begin
          if (bus.flush_e || !bus.stall_m) mulState <= StIdle;
        end
        default: mulState <= StIdle;
      endcase
    end
  end
`else
  logic unusedMul;
  assign unusedMul = bus.mul_e;
  assign mulIdle   = 1'b1;
  assign mulStart  = 1'b0;
`endif

  // Bubbles clear only valid and the write enables; data fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      validM     <= 1'b0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      resultSrcM <= '0;
      rdM        <= '0;
      aluResultM <= '0;
      writeDataM <= '0;
      pcPlus4M   <= '0;
    end else if (!bus.stall_m) begin
`ifdef EXEC_MUL_EN
      if (mulFire) begin
        validM     <= 1'b1;
        regWriteM  <= mulRegWrite;
        memWriteM  <= mulMemWrite;
        resultSrcM <= mulResultSrc;
        rdM        <= mulRd;
        aluResultM <= mulAcc;
        writeDataM <= mulWriteData;
        pcPlus4M   <= mulPcPlus4;
      end else
`endif
      if (accept && !mulStart) begin
        validM     <= 1'b1;
        regWriteM  <= bus.reg_write_e;
        memWriteM  <= bus.mem_write_e;
        resultSrcM <= bus.result_src_e;
        rdM        <= bus.rd_e;
        aluResultM <= aluResult;
        writeDataM <= fwdB;
        pcPlus4M   <= bus.pc_plus4_e;
      end else begin
        validM    <= 1'b0;
        regWriteM <= 1'b0;
        memWriteM <= 1'b0;
      end
    end
  end

  assign bus.valid_m      = validM;
  assign bus.reg_write_m  = regWriteM;
  assign bus.mem_write_m  = memWriteM;
  assign bus.result_src_m = resultSrcM;
  assign bus.rd_m         = rdM;
  assign bus.alu_result_m = aluResultM;
  assign bus.write_data_m = writeDataM;
  assign bus.pc_plus4_m   = pcPlus4M;

endmodule

// File: tb/tb_execute_stage_fwd.sv
// Bench for execute_stage_fwd: directed literal cases plus random traffic against a
// cycle-level reference model. MUL cases are active when EXEC_MUL_EN is defined.
module tb_execute_stage_fwd;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam logic [2:0] OpAdd = 3'b000, OpSub = 3'b001, OpSlt = 3'b101;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;

  execute_stage_fwd_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();
  execute_stage_fwd #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference state: what the E/M register must hold, plus remaining MUL cycles.
  logic            mValid, mRw, mMw, aluKnown;
  logic [1:0]      mRs;
  logic [RW-1:0]   mRd;
  logic [XLEN-1:0] mAlu, mWd, mPc4;
  int              mulLeft = 0;
  logic            cRw, cMw;
  logic [1:0]      cRs;
  logic [RW-1:0]   cRd;
  logic [XLEN-1:0] cProd, cWd, cPc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] aluRef(input logic [2:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] pick(input logic [1:0] code, input logic [XLEN-1:0] r,
                                           input logic [XLEN-1:0] w, input logic [XLEN-1:0] m);
    return (code == 2'b01) ? w : (code == 2'b10) ? m : r;
  endfunction

  task automatic opnds(output logic [XLEN-1:0] a, output logic [XLEN-1:0] b,
                       output logic [XLEN-1:0] bw);
    a  = pick(bus.forward_a_e, bus.rd1_e, bus.result_w, mAlu);
    bw = pick(bus.forward_b_e, bus.rd2_e, bus.result_w, mAlu);
    b  = bus.alu_src_e ? bus.imm_ext_e : bw;
  endtask

  always @(posedge clk) begin
    logic [XLEN-1:0] a, b, bw;
    logic            rdy, acc, isMul, fire;
    opnds(a, b, bw);
    rdy = !bus.stall_m && mulLeft == 0;
    acc = bus.valid_e && rdy && !bus.flush_e;
`ifdef EXEC_MUL_EN
    isMul = bus.mul_e;
`else
    isMul = 1'b0;
`endif
    fire = 1'b0;
    if (rst) begin
      {mValid, mRw, mMw, mRs, mRd, mAlu, mWd, mPc4} = '0;
      aluKnown = 1'b1;
      mulLeft  = 0;
    end else begin
      if (mulLeft == 1 && !bus.flush_e && !bus.stall_m) fire = 1'b1;
      if (!bus.stall_m) begin
        if (fire) begin
          {mValid, mRw, mMw, mRs, mRd} = {1'b1, cRw, cMw, cRs, cRd};
          {mAlu, mWd, mPc4} = {cProd, cWd, cPc4};
          aluKnown = 1'b1;
        end else if (acc && !isMul) begin
          {mValid, mRw, mMw, mRs, mRd} = {1'b1, bus.reg_write_e, bus.mem_write_e,
                                          bus.result_src_e, bus.rd_e};
          {mAlu, mWd, mPc4} = {aluRef(bus.alu_control_e, a, b), bw, bus.pc_plus4_e};
          aluKnown = 1'b1;
        end else begin
          {mValid, mRw, mMw} = 3'b000;
          aluKnown = 1'b0;
        end
      end
      if (mulLeft > 0) begin
        if (bus.flush_e || fire) mulLeft = 0;
        else if (mulLeft > 1) mulLeft--;
      end else if (acc && isMul) begin
        mulLeft = XLEN + 1;
        cProd   = a * b;
        {cRw, cMw, cRs, cRd, cWd, cPc4} = {bus.reg_write_e, bus.mem_write_e,
                                           bus.result_src_e, bus.rd_e, bw, bus.pc_plus4_e};
      end
    end
  end

  always @(negedge clk) begin
    logic [XLEN-1:0] a, b, bw, res;
    logic            rdy;
    if (!rst) begin
      opnds(a, b, bw);
      res = aluRef(bus.alu_control_e, a, b);
      rdy = !bus.stall_m && mulLeft == 0;
      chk("ready_e", 32'(bus.ready_e), 32'(rdy));
      chk("pc_src_e", 32'(bus.pc_src_e),
          32'(bus.valid_e && rdy && !bus.flush_e && bus.branch_e && res == 0));
      chk("pc_target_e", bus.pc_target_e, bus.pc_e + bus.imm_ext_e);
      chk("valid_m", 32'(bus.valid_m), 32'(mValid));
      chk("reg_write_m", 32'(bus.reg_write_m), 32'(mRw));
      chk("mem_write_m", 32'(bus.mem_write_m), 32'(mMw));
      if (mValid) begin
        chk("alu_result_m", bus.alu_result_m, mAlu);
        chk("write_data_m", bus.write_data_m, mWd);
        chk("pc_plus4_m", bus.pc_plus4_m, mPc4);
        chk("rd_m", 32'(bus.rd_m), 32'(mRd));
        chk("result_src_m", 32'(bus.result_src_m), 32'(mRs));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    {bus.valid_e, bus.flush_e, bus.stall_m, bus.alu_src_e, bus.reg_write_e} = '0;
    {bus.mem_write_e, bus.branch_e, bus.mul_e} = '0;
    {bus.rd1_e, bus.rd2_e, bus.imm_ext_e, bus.pc_e, bus.pc_plus4_e, bus.result_w} = '0;
    bus.alu_control_e = '0;
    bus.result_src_e  = '0;
    bus.rd_e          = '0;
    bus.forward_a_e   = '0;
    bus.forward_b_e   = '0;
  endtask

  task automatic instr(input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                       input logic [2:0] op, input logic [RW-1:0] rd);
    bus.valid_e       = 1'b1;
    bus.rd1_e         = r1;
    bus.rd2_e         = r2;
    bus.alu_control_e = op;
    bus.rd_e          = rd;
    bus.reg_write_e   = 1'b1;
  endtask

  initial begin
    int busy;
    int seen;
    clearIn();
    rst         = 1'b1;
    bus.stall_m = 1'b1;
    step();
    rst         = 1'b0;
    bus.stall_m = 1'b0;
    #2;
    chk("rst valid_m", 32'(bus.valid_m), 0);
    chk("rst reg_write_m", 32'(bus.reg_write_m), 0);
    chk("rst mem_write_m", 32'(bus.mem_write_m), 0);
    chk("rst result_src_m", 32'(bus.result_src_m), 0);
    chk("rst rd_m", 32'(bus.rd_m), 0);
    chk("rst alu_result_m", bus.alu_result_m, 0);
    chk("rst write_data_m", bus.write_data_m, 0);
    chk("rst pc_plus4_m", bus.pc_plus4_m, 0);
    chk("rst ready_e", 32'(bus.ready_e), 1);

    clearIn(); instr(3, 4, OpAdd, 1);
    step(); #2;
    chk("add alu", bus.alu_result_m, 7);
    chk("add valid", 32'(bus.valid_m), 1);
    chk("add rd", 32'(bus.rd_m), 1);
    clearIn(); instr(5, 3, OpAdd, 2); bus.forward_a_e = 2'b10;
    step(); #2;
    chk("fwd M alu", bus.alu_result_m, 10);
    clearIn(); instr(100, 2, OpAdd, 3); bus.forward_a_e = 2'b01; bus.result_w = 40;
    step(); #2;
    chk("fwd W alu", bus.alu_result_m, 42);
    clearIn(); instr(1, 99, OpAdd, 4); bus.forward_a_e = 2'b11;
    bus.alu_src_e = 1'b1; bus.imm_ext_e = 32'h10; bus.pc_plus4_e = 32'h44;
    step(); #2;
    chk("imm alu", bus.alu_result_m, 32'h11);
    chk("imm write_data", bus.write_data_m, 99);
    chk("imm pc_plus4", bus.pc_plus4_m, 32'h44);
    clearIn(); instr(32'hFFFF_FFFF, 1, OpSlt, 5);
    step(); #2;
    chk("slt alu", bus.alu_result_m, 1);
    clearIn(); instr(7, 7, 3'b110, 5);
    step(); #2;
    chk("undef op alu", bus.alu_result_m, 0);

    clearIn(); instr(9, 9, OpSub, 0); bus.reg_write_e = 1'b0;
    bus.branch_e = 1'b1; bus.pc_e = 32'h100; bus.imm_ext_e = 32'h20;
    #1;
    chk("branch pc_src", 32'(bus.pc_src_e), 1);
    chk("branch target", bus.pc_target_e, 32'h120);
    bus.flush_e = 1'b1;
    #1;
    chk("flush pc_src", 32'(bus.pc_src_e), 0);
    step(); #2;
    chk("flush bubble", 32'(bus.valid_m), 0);

    clearIn(); instr(1, 2, OpAdd, 6); bus.mem_write_e = 1'b1;
    step(); #2;
    chk("pre-stall alu", bus.alu_result_m, 3);
    clearIn(); instr(5, 6, OpAdd, 7); bus.mem_write_e = 1'b1; bus.stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall ready", 32'(bus.ready_e), 0);
      step(); #2;
      chk("stall hold alu", bus.alu_result_m, 3);
      chk("stall hold rd", 32'(bus.rd_m), 6);
    end
    bus.stall_m = 1'b0;
    #1;
    chk("release ready", 32'(bus.ready_e), 1);
    step(); #2;
    chk("release alu", bus.alu_result_m, 11);
    chk("release rd", 32'(bus.rd_m), 7);
    clearIn();
    step(); #2;
    chk("bubble valid", 32'(bus.valid_m), 0);
    chk("bubble reg_write", 32'(bus.reg_write_m), 0);
    chk("bubble mem_write", 32'(bus.mem_write_m), 0);

`ifdef EXEC_MUL_EN
    clearIn(); instr(32'hFFFF_FFFF, 3, OpAdd, 9); bus.mul_e = 1'b1;
    step(); clearIn();
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (bus.ready_e) break;
      busy++;
      step();
    end
    chk("mul busy cycles", busy, XLEN + 1);
    chk("mul valid", 32'(bus.valid_m), 1);
    chk("mul product", bus.alu_result_m, 32'hFFFF_FFFD);
    chk("mul rd", 32'(bus.rd_m), 9);
    step();
    clearIn(); instr(7, 7, OpAdd, 10); bus.mul_e = 1'b1;
    step(); clearIn();
    repeat (5) step();
    bus.flush_e = 1'b1;
    step(); clearIn(); #2;
    chk("mul abort ready", 32'(bus.ready_e), 1);
    seen = 0;
    repeat (XLEN + 4) begin
      step(); #2;
      if (bus.valid_m) seen++;
    end
    chk("mul abort no result", seen, 0);
`else
    clearIn(); instr(2, 3, OpAdd, 11); bus.mul_e = 1'b1;
    #1;
    chk("mul ignored ready", 32'(bus.ready_e), 1);
    step(); #2;
    chk("mul ignored alu", bus.alu_result_m, 5);
    chk("mul ignored valid", 32'(bus.valid_m), 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      bus.valid_e       = ($urandom_range(0, 3) != 0);
      bus.flush_e       = ($urandom_range(0, 19) == 0);
      bus.stall_m       = ($urandom_range(0, 4) == 0);
      bus.rd1_e         = $urandom_range(0, 1) ? XLEN'($urandom_range(0, 3)) : $urandom;
      bus.rd2_e         = $urandom_range(0, 1) ? XLEN'($urandom_range(0, 3)) : $urandom;
      bus.imm_ext_e     = $urandom;
      bus.pc_e          = $urandom;
      bus.pc_plus4_e    = $urandom;
      bus.result_w      = $urandom_range(0, 1) ? XLEN'($urandom_range(0, 3)) : $urandom;
      bus.alu_control_e = 3'($urandom_range(0, 7));
      bus.alu_src_e     = ($urandom_range(0, 3) == 0);
      bus.reg_write_e   = 1'($urandom_range(0, 1));
      bus.mem_write_e   = 1'($urandom_range(0, 1));
      bus.branch_e      = 1'($urandom_range(0, 1));
      bus.mul_e         = ($urandom_range(0, 15) == 0);
      bus.result_src_e  = 2'($urandom_range(0, 3));
      bus.rd_e          = RW'($urandom_range(0, 31));
      bus.forward_a_e   = 2'($urandom_range(0, 3));
      bus.forward_b_e   = 2'($urandom_range(0, 3));
      // alu_result_m content after a bubble is not architectural, so avoid forwarding it
      if (!aluKnown && bus.forward_a_e == 2'b10) bus.forward_a_e = 2'b00;
      if (!aluKnown && bus.forward_b_e == 2'b10) bus.forward_b_e = 2'b00;
    end
    step();
    rst = 1'b0;
    clearIn();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
